// File: rtl/mips_debug_ctrl_if.sv
// mips_debug_ctrl_if: run-control bus between debugger/core and mips_debug_ctrl.
// master drives requests, breakpoint programming and pc; slave returns cpu_en and status.
interface mips_debug_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int STEP_W     = 16,
  parameter int CNT_W      = 32
);
  logic                  debug_en;
  logic                  debug_step;
  logic                  run_req;
  logic                  halt_req;
  logic                  step_req;
  logic [STEP_W-1:0]     step_count;
  logic                  bp_wen;
  logic [3:0]            bp_idx;
  logic [ADDR_WIDTH-1:0] bp_addr;
  logic                  bp_valid;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  cpu_en;
  logic                  halted;
  logic                  bp_hit;
  logic [3:0]            bp_hit_idx;
  logic [STEP_W-1:0]     steps_left;
  logic [CNT_W-1:0]      instr_cnt;
  modport master (
    output debug_en, debug_step, run_req, halt_req, step_req, step_count,
           bp_wen, bp_idx, bp_addr, bp_valid, pc,
    input  cpu_en, halted, bp_hit, bp_hit_idx, steps_left, instr_cnt
  );
  modport slave (
    input  debug_en, debug_step, run_req, halt_req, step_req, step_count,
           bp_wen, bp_idx, bp_addr, bp_valid, pc,
    output cpu_en, halted, bp_hit, bp_hit_idx, steps_left, instr_cnt
  );
endinterface

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: MIPS run control with breakpoints, step bursts, run/halt and retired count.
// Ports: clk, rst (sync, active-low), bus (slave): requests/breakpoint writes/pc in,
// cpu_en, halted, bp_hit, bp_hit_idx, steps_left, instr_cnt out.
module mips_debug_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BP     = 4,
  parameter int STEP_W     = 16,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  mips_debug_ctrl_if.slave bus
);
  typedef enum logic [1:0] {HALT, RUN, STEP} state_t;
  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_BP];
  logic [NUM_BP-1:0]     slot_valid;
  logic                  skip, step_q, den_q, bp_any, bp_match, cpu_en;
  logic                  bp_hit, bp_hit_n;
  logic [3:0]            hit_idx, bp_hit_idx, bp_hit_idx_n;
  logic [STEP_W-1:0]     steps_left, steps_n;
  logic [CNT_W-1:0]      instr_cnt;
  // Scan from the top so the lowest matching slot is the one left in hit_idx.
  always_comb begin
    bp_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (slot_valid[i] && slot_addr[i][ADDR_WIDTH-1:2] == bus.pc[ADDR_WIDTH-1:2]) begin
        bp_any = 1'b1;
        hit_idx = 4'(i);
      end
  end
  assign bp_match = bus.debug_en & bp_any;
  // skip lets the first instruction after leaving HALT execute even if it sits on a breakpoint.
  assign cpu_en = (state != HALT) && !(bp_match && !skip);
  always_comb begin
    state_n = state;
    steps_n = steps_left;
    bp_hit_n = bp_hit;
    bp_hit_idx_n = bp_hit_idx;
    if (!bus.debug_en) begin
      state_n = RUN;
      steps_n = '0;
    end else if (!den_q) begin
      state_n = HALT;
      steps_n = '0;
    end else if (state != HALT && bus.halt_req) begin
      state_n = HALT;
      steps_n = '0;
    end else if (state != HALT && bp_match && !skip) begin
      state_n = HALT;
      bp_hit_n = 1'b1;
      bp_hit_idx_n = hit_idx;
      steps_n = '0;
    end else if (state == STEP) begin
      steps_n = steps_left - 1'b1;
      state_n = steps_left <= 1 ? HALT : STEP;
    end else if (state == HALT) begin
      if (bus.step_req) begin
        if (bus.step_count != '0) begin
          state_n = STEP;
          steps_n = bus.step_count;
        end
      end else if (bus.debug_step && !step_q) begin
        state_n = STEP;
        steps_n = 1;
      end else if (bus.run_req) begin
        state_n = RUN;
      end
    end
    if (state == HALT && state_n != HALT) bp_hit_n = 1'b0;
  end
  always_ff @(posedge clk) begin
    den_q <= bus.debug_en;
    if (!rst) begin
      state <= HALT;
      steps_left <= '0;
      instr_cnt <= '0;
      bp_hit <= 1'b0;
      bp_hit_idx <= '0;
      slot_valid <= '0;
      step_q <= 1'b0;
      skip <= 1'b0;
    end else begin
      state <= state_n;
      steps_left <= steps_n;
      bp_hit <= bp_hit_n;
      bp_hit_idx <= bp_hit_idx_n;
      step_q <= bus.debug_step;
      skip <= state == HALT && state_n != HALT;
      instr_cnt <= instr_cnt + CNT_W'(cpu_en);
      for (int i = 0; i < NUM_BP; i++)
        if (bus.bp_wen && bus.bp_idx == 4'(i)) begin
          slot_addr[i] <= bus.bp_addr;
          slot_valid[i] <= bus.bp_valid;
        end
    end
  end
  assign bus.cpu_en = cpu_en;
  assign bus.halted = state == HALT;
  assign bus.bp_hit = bp_hit;
  assign bus.bp_hit_idx = bp_hit_idx;
  assign bus.steps_left = steps_left;
  assign bus.instr_cnt = instr_cnt;
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl: directed self-checking bench for mips_debug_ctrl.
module tb_mips_debug_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mips_debug_ctrl_if bus ();
  mips_debug_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int cmp = 0;
  int err = 0;
  int en_cnt = 0;
  bit follow = 1'b1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock: sample cpu_en just before the edge, then advance the pc like the core would.
  task automatic cyc();
    logic en;
    #1 en = bus.cpu_en;
    if (en === 1'b1) en_cnt++;
    @(posedge clk);
    #1;
    if (follow && en === 1'b1) bus.pc = bus.pc + 32'd4;
    #1;
  endtask
  task automatic wr_bp(input logic [3:0] idx, input logic [31:0] addr);
    bus.bp_wen = 1'b1;
    bus.bp_idx = idx;
    bus.bp_addr = addr;
    bus.bp_valid = 1'b1;
    cyc();
    bus.bp_wen = 1'b0;
  endtask
  initial begin
    bus.debug_en = 1'b1;
    bus.debug_step = 1'b0;
    bus.run_req = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.step_count = '0;
    bus.bp_wen = 1'b0;
    bus.bp_idx = '0;
    bus.bp_addr = '0;
    bus.bp_valid = 1'b0;
    bus.pc = '0;
    repeat (2) cyc();
    rst = 1'b1;
    #1;
    chk("rst_cpu_en", bus.cpu_en, 0);
    chk("rst_halted", bus.halted, 1);
    chk("rst_instr_cnt", bus.instr_cnt, 0);
    chk("rst_steps_left", bus.steps_left, 0);
    chk("rst_bp_hit", bus.bp_hit, 0);
    en_cnt = 0;
    bus.step_req = 1'b1;
    bus.step_count = 16'd3;
    cyc();
    bus.step_req = 1'b0;
    chk("step3_steps_left", bus.steps_left, 3);
    chk("step3_cpu_en", bus.cpu_en, 1);
    repeat (6) cyc();
    chk("step3_en_cycles", en_cnt, 3);
    chk("step3_instr_cnt", bus.instr_cnt, 3);
    chk("step3_halted", bus.halted, 1);
    chk("step3_steps_left_end", bus.steps_left, 0);
    chk("step3_pc", bus.pc, 32'hC);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    bus.pc = '0;
    wr_bp(4'd2, 32'h10);
    bus.run_req = 1'b1;
    cyc();
    bus.run_req = 1'b0;
    repeat (8) cyc();
    chk("bp_halted", bus.halted, 1);
    chk("bp_hit", bus.bp_hit, 1);
    chk("bp_hit_idx", bus.bp_hit_idx, 2);
    chk("bp_instr_cnt", bus.instr_cnt, 4);
    chk("bp_pc", bus.pc, 32'h10);
    chk("bp_cpu_en", bus.cpu_en, 0);
    wr_bp(4'd0, 32'h20);
    wr_bp(4'd3, 32'h20);
    bus.run_req = 1'b1;
    cyc();
    bus.run_req = 1'b0;
    chk("resume_cpu_en", bus.cpu_en, 1);
    chk("resume_bp_hit_clr", bus.bp_hit, 0);
    repeat (6) cyc();
    chk("resume_halted", bus.halted, 1);
    chk("resume_bp_hit", bus.bp_hit, 1);
    chk("resume_bp_idx_low", bus.bp_hit_idx, 0);
    chk("resume_instr_cnt", bus.instr_cnt, 8);
    chk("resume_pc", bus.pc, 32'h20);
    bus.run_req = 1'b1;
    cyc();
    bus.run_req = 1'b0;
    bus.halt_req = 1'b1;
    cyc();
    bus.halt_req = 1'b0;
    chk("halt_req_halted", bus.halted, 1);
    chk("halt_req_instr_cnt", bus.instr_cnt, 9);
    chk("halt_req_bp_hit", bus.bp_hit, 0);
    bus.debug_step = 1'b1;
    cyc();
    chk("dstep_steps_left", bus.steps_left, 1);
    repeat (3) cyc();
    bus.debug_step = 1'b0;
    cyc();
    chk("dstep_instr_cnt", bus.instr_cnt, 10);
    chk("dstep_pc", bus.pc, 32'h28);
    bus.step_req = 1'b1;
    bus.step_count = 16'd0;
    cyc();
    bus.step_req = 1'b0;
    chk("step0_halted", bus.halted, 1);
    chk("step0_cpu_en", bus.cpu_en, 0);
    cyc();
    chk("step0_instr_cnt", bus.instr_cnt, 10);
    bus.step_req = 1'b1;
    bus.step_count = 16'd5;
    cyc();
    bus.step_req = 1'b0;
    repeat (2) cyc();
    chk("step5_mid_steps_left", bus.steps_left, 3);
    bus.halt_req = 1'b1;
    cyc();
    bus.halt_req = 1'b0;
    chk("step5_halt_steps_left", bus.steps_left, 0);
    chk("step5_halt_halted", bus.halted, 1);
    chk("step5_halt_instr_cnt", bus.instr_cnt, 13);
    chk("step5_pc", bus.pc, 32'h34);
    follow = 1'b0;
    wr_bp(4'd1, 32'h34);
    chk("dis_pre_cpu_en", bus.cpu_en, 0);
    bus.debug_en = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("dis_cpu_en", bus.cpu_en, 1);
      cyc();
    end
    bus.debug_en = 1'b1;
    cyc();
    chk("reen_halted", bus.halted, 1);
    chk("reen_instr_cnt", bus.instr_cnt, 16);
    chk("reen_bp_hit", bus.bp_hit, 0);
    follow = 1'b1;
    bus.step_req = 1'b1;
    bus.step_count = 16'd9;
    cyc();
    bus.step_req = 1'b0;
    repeat (2) cyc();
    chk("burst_steps_left", bus.steps_left, 7);
    chk("burst_halted", bus.halted, 0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("mrst_halted", bus.halted, 1);
    chk("mrst_steps_left", bus.steps_left, 0);
    chk("mrst_instr_cnt", bus.instr_cnt, 0);
    follow = 1'b0;
    bus.pc = 32'h34;
    bus.run_req = 1'b1;
    cyc();
    bus.run_req = 1'b0;
    cyc();
    chk("mrst_slots_invalid", bus.cpu_en, 1);
    bus.halt_req = 1'b1;
    cyc();
    bus.halt_req = 1'b0;
    chk("mrst_halt", bus.halted, 1);
    wr_bp(4'd4, 32'h34);
    bus.run_req = 1'b1;
    cyc();
    bus.run_req = 1'b0;
    cyc();
    chk("oob_cpu_en", bus.cpu_en, 1);
    chk("oob_halted", bus.halted, 0);
    bus.halt_req = 1'b1;
    cyc();
    bus.halt_req = 1'b0;
    wr_bp(4'd3, 32'h34);
    bus.run_req = 1'b1;
    cyc();
    bus.run_req = 1'b0;
    chk("slot3_skip_cpu_en", bus.cpu_en, 1);
    cyc();
    chk("slot3_cpu_en", bus.cpu_en, 0);
    cyc();
    chk("slot3_halted", bus.halted, 1);
    chk("slot3_bp_hit", bus.bp_hit, 1);
    chk("slot3_bp_idx", bus.bp_hit_idx, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
